cmd_cfg_mc: RTL
===============

CMD_CFG_MC -- requirements
Module: cmd_cfg_mc

Interface
REQ-001 Parameter NUM_CH, default 5; number of capture channels, legal range 1..7.
REQ-002 Parameter ENTRIES, default 384; samples per channel RAM.
REQ-003 Parameter LOG2, default 9; RAM address width, with 2^LOG2 >= ENTRIES.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 cmd  input  16  host command; stable while cmd_rdy is high.
REQ-007 cmd_rdy  input  1  command valid.
REQ-008 resp_sent  input  1  one-cycle pulse; UART finished transmitting resp.
REQ-009 set_capture_done  input  1  capture finished.
REQ-010 ram_addr  input  LOG2  oldest-sample address, which is also the next write location.
REQ-011 rdata  input  8*NUM_CH  RAM read data; channel n occupies bits [8n-1:8n-8]; valid 1 cycle after raddr.
REQ-012 raddr  output  LOG2  shared RAM read address.
REQ-013 TrigCfg  output  6; decimator  output  4; VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL  output  8 each; configuration registers.
REQ-014 ch_trig_cfg  output  5*NUM_CH  per-channel trigger configuration; channel n occupies bits [5n-1:5n-5].
REQ-015 trig_pos  output  LOG2  equals {trig_posH, trig_posL}[LOG2-1:0].
REQ-016 resp  output  8  response byte; send_resp  output  1  one-cycle transmit pulse; clr_cmd_rdy  output  1  one-cycle command-consumed pulse.

Function
REQ-017 Command decode: op = cmd[15:14], addr = cmd[13:8], data = cmd[7:0]; op 00 RD, 01 WR, 10 DUMP, 11 reserved.
REQ-018 Register map: 0x00 TrigCfg; 0x06 decimator; 0x07 VIH; 0x08 VIL; 0x09 matchH; 0x0A matchL; 0x0B maskH; 0x0C maskL; 0x0D baud_cntH; 0x0E baud_cntL; 0x0F trig_posH; 0x10 trig_posL; 0x20+(n-1) channel n trigger config, n = 1..NUM_CH.
REQ-019 Reset values: TrigCfg 0x03; every channel trigger config 0x01; decimator 0x0; VIH 0xAA; VIL 0x55; match and mask registers 0x00; baud_cntH 0x06; baud_cntL 0xC8; trig_posH 0x00; trig_posL 0x01; resp 0x00; raddr 0; send_resp 0; clr_cmd_rdy 0; FSM in IDLE.
REQ-020 FSM states: IDLE, RESP, DMP_ADDR, DMP_DATA, DMP_WAIT, DONE.
REQ-021 IDLE, cmd_rdy high at edge k:
- decode happens at edge k;
- resp is valid at k+1 and send_resp is high for exactly cycle k+1;
- a WR register update is visible at k+1.
REQ-022 RD of a mapped address: resp = register value, zero-extended to 8 bits; then go to RESP.
REQ-023 RD of an unmapped address: resp = 0x00; then go to RESP.
REQ-024 WR of a mapped address: register <= data (truncated to register width); resp = 0xA5 (ACK); then go to RESP.
REQ-025 WR of an unmapped address: no register changes; resp = 0xEE (NACK); then go to RESP.
REQ-026 op 11: resp = 0xEE; then go to RESP.
REQ-027 RESP: wait for resp_sent, then go to DONE.
REQ-028 DONE: clr_cmd_rdy = 1 for one cycle, then go to IDLE; IDLE ignores cmd_rdy during the DONE cycle.
REQ-029 DUMP channel selection: ch = cmd[10:8]; ch = 0 or ch > NUM_CH gives resp = 0xEE and a transition to RESP, with no RAM access.
REQ-030 DUMP length: N = ENTRIES if data = 0, otherwise min(data, ENTRIES).
REQ-031 DUMP start address: (ram_addr + ENTRIES - N) mod ENTRIES, i.e. the N most recent samples, oldest first.
REQ-032 DMP_ADDR: raddr is driven for one cycle.
REQ-033 DMP_DATA: at the end of this cycle, resp <= selected channel byte; send_resp is high in the first DMP_WAIT cycle.
REQ-034 DMP_WAIT, on resp_sent:
- remaining = 1: go to DONE;
- otherwise: raddr <= raddr + 1, wrapping ENTRIES-1 -> 0; remaining decrements; go to DMP_ADDR.
REQ-035 A dump sends exactly N bytes, has exactly one send_resp per byte, and issues clr_cmd_rdy only after the final resp_sent.
REQ-036 resp holds its value from the send_resp cycle until the next send_resp.
REQ-037 set_capture_done sets TrigCfg[5] from any state.
REQ-038 set_capture_done in the same cycle as a WR to 0x00: TrigCfg = {1, data[4:0]}.
REQ-039 TrigCfg[5] is cleared only by a WR to 0x00 or by reset.
REQ-040 resp_sent outside RESP and DMP_WAIT is ignored.
REQ-041 raddr holds its value outside the DUMP states.

Reset
REQ-042 rst_n low in any state, including mid-dump, immediately forces every REQ-019 value and suppresses send_resp and clr_cmd_rdy.
REQ-043 The first command after rst_n deasserts is accepted on the first edge at which cmd_rdy is sampled high.

Verification
REQ-044 After reset, RD 0x0D -> resp 0x06; RD 0x20 -> resp 0x01; RD 0x3F -> resp 0x00; each read gives one send_resp and one clr_cmd_rdy after resp_sent.
REQ-045 WR 0x07 = 0x3C -> VIH = 0x3C at k+1 and resp 0xA5; WR 0x11 -> resp 0xEE with all registers unchanged.
REQ-046 NUM_CH = 5, ENTRIES = 384, ram_addr = 5, DUMP ch 3 with data 0 -> 384 bytes from addresses 5..383 then 0..4; each byte equals the channel-3 RAM contents; clr_cmd_rdy after the 384th resp_sent.
REQ-047 ram_addr = 2, DUMP ch 1 with data 4 -> addresses 382, 383, 0, 1; exactly 4 send_resp pulses.
REQ-048 DUMP ch 6 with NUM_CH = 5 -> resp 0xEE and no raddr change; set_capture_done together with WR 0x00 = 0x01 -> TrigCfg 0x21.
REQ-049 rst_n asserted after the 10th dump byte -> all outputs at reset values and state IDLE; a following RD 0x00 returns 0x03.

Source files
------------

// File: rtl/cmd_cfg_mc.sv
// cmd_cfg_mc: host command processor for the capture configuration registers.
// Decodes 16-bit host commands (RD / WR / DUMP), holds the configuration
// register file and streams per-channel capture RAM contents back over the
// response byte interface.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd, cmd_rdy        host command and its valid flag
//   resp_sent           UART finished transmitting resp (one-cycle pulse)
//   set_capture_done    sets TrigCfg[5]
//   ram_addr            oldest-sample / next-write address of the capture RAM
//   rdata               RAM read data, 8 bits per channel, 1-cycle latency
//   raddr               shared RAM read address
//   TrigCfg .. trig_pos configuration register outputs
//   resp, send_resp     response byte and its one-cycle transmit pulse
//   clr_cmd_rdy         one-cycle command-consumed pulse
module cmd_cfg_mc #(
    parameter int unsigned NUM_CH  = 5,
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned LOG2    = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           cmd,
    input  logic                  cmd_rdy,
    input  logic                  resp_sent,
    input  logic                  set_capture_done,
    input  logic [LOG2-1:0]       ram_addr,
    input  logic [8*NUM_CH-1:0]   rdata,
    output logic [LOG2-1:0]       raddr,
    output logic [5:0]            TrigCfg,
    output logic [3:0]            decimator,
    output logic [7:0]            VIH,
    output logic [7:0]            VIL,
    output logic [7:0]            matchH,
    output logic [7:0]            matchL,
    output logic [7:0]            maskH,
    output logic [7:0]            maskL,
    output logic [7:0]            baud_cntH,
    output logic [7:0]            baud_cntL,
    output logic [5*NUM_CH-1:0]   ch_trig_cfg,
    output logic [LOG2-1:0]       trig_pos,
    output logic [7:0]            resp,
    output logic                  send_resp,
    output logic                  clr_cmd_rdy
);

    // Byte counter must hold ENTRIES and any 8-bit length request.
    localparam int unsigned CNT_W = (LOG2 + 1 > 9) ? LOG2 + 1 : 9;
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;

    localparam logic [7:0] ACK  = 8'hA5;
    localparam logic [7:0] NACK = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        RESP,
        DMP_ADDR,
        DMP_DATA,
        DMP_WAIT,
        DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       remaining, remaining_nxt;
    logic [2:0]             ch_sel, ch_sel_nxt;
    logic [LOG2-1:0]        raddr_nxt;
    logic [7:0]             resp_nxt;
    logic                   send_nxt;
    logic                   clr_nxt;
    logic                   wr_en;
    logic [7:0]             trig_pos_h, trig_pos_l;

    logic [1:0]             op;
    logic [5:0]             addr;
    logic [7:0]             data;
    logic [2:0]             dump_ch;

    assign op      = cmd[15:14];
    assign addr    = cmd[13:8];
    assign data    = cmd[7:0];
    assign dump_ch = cmd[10:8];

    // trig_pos is a fixed slice of the two position registers.
    assign trig_pos = LOG2'({trig_pos_h, trig_pos_l});

    // Register read mux; unmapped addresses read as zero.
    logic [7:0] rd_val;
    logic       mapped;
    always_comb begin
        rd_val = 8'h00;
        mapped = 1'b1;
        case (addr)
            6'h00:   rd_val = {2'b00, TrigCfg};
            6'h06:   rd_val = {4'h0, decimator};
            6'h07:   rd_val = VIH;
            6'h08:   rd_val = VIL;
            6'h09:   rd_val = matchH;
            6'h0A:   rd_val = matchL;
            6'h0B:   rd_val = maskH;
            6'h0C:   rd_val = maskL;
            6'h0D:   rd_val = baud_cntH;
            6'h0E:   rd_val = baud_cntL;
            6'h0F:   rd_val = trig_pos_h;
            6'h10:   rd_val = trig_pos_l;
            default: mapped = 1'b0;
        endcase
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (addr == 6'(32 + i)) begin
                rd_val = {3'b000, ch_trig_cfg[5*i +: 5]};
                mapped = 1'b1;
            end
        end
    end

    // Dump length and start address: the N most recent samples, oldest first.
    logic [CNT_W-1:0] dump_len;
    logic [SUM_W-1:0] dump_sum;
    logic [LOG2-1:0]  dump_start;
    logic             dump_ch_ok;
    always_comb begin
        if (data == 8'h00 || CNT_W'(data) > CNT_W'(ENTRIES)) begin
            dump_len = CNT_W'(ENTRIES);
        end else begin
            dump_len = CNT_W'(data);
        end
        dump_sum = SUM_W'(ram_addr) + SUM_W'(ENTRIES) - SUM_W'(dump_len);
        if (dump_sum >= SUM_W'(ENTRIES)) begin
            dump_sum = dump_sum - SUM_W'(ENTRIES);
        end
        dump_start = LOG2'(dump_sum);
        dump_ch_ok = (dump_ch != 3'd0) && (32'(dump_ch) <= NUM_CH);
    end

    // Selected channel byte from the RAM read data.
    logic [7:0] dmp_byte;
    always_comb begin
        dmp_byte = 8'h00;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 3'(i + 1)) begin
                dmp_byte = rdata[8*i +: 8];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt     = state;
        resp_nxt      = resp;
        raddr_nxt     = raddr;
        remaining_nxt = remaining;
        ch_sel_nxt    = ch_sel;
        send_nxt      = 1'b0;
        clr_nxt       = 1'b0;
        wr_en         = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_rdy) begin
                    state_nxt = RESP;
                    send_nxt  = 1'b1;
                    case (op)
                        OP_RD: resp_nxt = rd_val;
                        OP_WR: begin
                            wr_en    = mapped;
                            resp_nxt = mapped ? ACK : NACK;
                        end
                        OP_DUMP: begin
                            if (dump_ch_ok) begin
                                state_nxt     = DMP_ADDR;
                                send_nxt      = 1'b0;
                                raddr_nxt     = dump_start;
                                remaining_nxt = dump_len;
                                ch_sel_nxt    = dump_ch;
                            end else begin
                                resp_nxt = NACK;
                            end
                        end
                        default: resp_nxt = NACK;
                    endcase
                end
            end
            RESP: begin
                if (resp_sent) begin
                    state_nxt = DONE;
                    clr_nxt   = 1'b1;
                end
            end
            DMP_ADDR: state_nxt = DMP_DATA;
            DMP_DATA: begin
                resp_nxt  = dmp_byte;
                send_nxt  = 1'b1;
                state_nxt = DMP_WAIT;
            end
            DMP_WAIT: begin
                if (resp_sent) begin
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = DONE;
                        clr_nxt   = 1'b1;
                    end else begin
                        raddr_nxt     = (raddr == LOG2'(ENTRIES - 1)) ? '0 : raddr + LOG2'(1);
                        remaining_nxt = remaining - CNT_W'(1);
                        state_nxt     = DMP_ADDR;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            resp        <= 8'h00;
            raddr       <= '0;
            remaining   <= '0;
            ch_sel      <= 3'd0;
            send_resp   <= 1'b0;
            clr_cmd_rdy <= 1'b0;
        end else begin
            state       <= state_nxt;
            resp        <= resp_nxt;
            raddr       <= raddr_nxt;
            remaining   <= remaining_nxt;
            ch_sel      <= ch_sel_nxt;
            send_resp   <= send_nxt;
            clr_cmd_rdy <= clr_nxt;
        end
    end

    // Configuration register file; capture-done wins bit 5 over a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TrigCfg     <= 6'h03;
            decimator   <= 4'h0;
            VIH         <= 8'hAA;
            VIL         <= 8'h55;
            matchH      <= 8'h00;
            matchL      <= 8'h00;
            maskH       <= 8'h00;
            maskL       <= 8'h00;
            baud_cntH   <= 8'h06;
            baud_cntL   <= 8'hC8;
            trig_pos_h  <= 8'h00;
            trig_pos_l  <= 8'h01;
            ch_trig_cfg <= {NUM_CH{5'h01}};
        end else begin
            if (wr_en) begin
                case (addr)
                    6'h00:   TrigCfg    <= data[5:0];
                    6'h06:   decimator  <= data[3:0];
                    6'h07:   VIH        <= data;
                    6'h08:   VIL        <= data;
                    6'h09:   matchH     <= data;
                    6'h0A:   matchL     <= data;
                    6'h0B:   maskH      <= data;
                    6'h0C:   maskL      <= data;
                    6'h0D:   baud_cntH  <= data;
                    6'h0E:   baud_cntL  <= data;
                    6'h0F:   trig_pos_h <= data;
                    6'h10:   trig_pos_l <= data;
                    default: ;
                endcase
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (addr == 6'(32 + i)) begin
                        ch_trig_cfg[5*i +: 5] <= data[4:0];
                    end
                end
            end
            if (set_capture_done) begin
                TrigCfg[5] <= 1'b1;
            end
        end
    end

endmodule
